// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store requester and the memory responder.
// Latency: none, wires only.
// Backpressure: req_ready throttles requests, rsp_ready throttles responses.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data memory with byte-enable stores, one request in flight, LATENCY wait states.
// Latency: accept at edge N, access at edge N+LATENCY, rsp_valid seen at edge N+LATENCY+1.
// Backpressure: response held until rsp_ready; DMEM_RESP_PIPELINE_EN overlaps next accept with it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             i_clk,
  input logic             i_rst,
  dmem_responder_if.slave s_bus
);

  localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit         LAT0   = (LATENCY == 0);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_req_ready, w_accept, w_access, w_rsp_done;
  logic          w_acc_we, w_acc_err;
  logic [31:0]   w_acc_addr, w_acc_wdata;
  logic [3:0]    w_acc_be;
  logic [AW-1:0] w_acc_idx;

  // Request acceptance: always in IDLE, and alongside the response handshake when pipelined.
  always_comb begin
    w_req_ready = 1'b0;
    case (r_state)
      IDLE: w_req_ready = 1'b1;
`ifdef DMEM_RESP_PIPELINE_EN
      RESP: w_req_ready = s_bus.rsp_ready;
`endif
      default: w_req_ready = 1'b0;
    endcase
  end

  assign w_accept   = s_bus.req_valid && w_req_ready;
  assign w_rsp_done = (r_state == RESP) && s_bus.rsp_ready;
  // i_rst gating keeps a zero-latency accept from touching the array while reset is held.
  assign w_access   = i_rst && (((r_state == WAIT) && (r_cnt == 4'd0)) || (w_accept && LAT0));

  // With zero latency the access uses the live request; otherwise the latched copy.
  assign w_acc_we    = (r_state == WAIT) ? r_we    : s_bus.req_we;
  assign w_acc_addr  = (r_state == WAIT) ? r_addr  : s_bus.req_addr;
  assign w_acc_wdata = (r_state == WAIT) ? r_wdata : s_bus.req_wdata;
  assign w_acc_be    = (r_state == WAIT) ? r_be    : s_bus.req_be;
  assign w_acc_idx   = w_acc_addr[AW+1:2];
  assign w_acc_err   = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));

  // Next state and wait counter.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next    = LAT0 ? RESP : WAIT;
          w_cnt_nxt = LAT_M1;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
        else               w_cnt_nxt = r_cnt - 4'd1;
      end
      RESP: begin
        if (w_rsp_done) begin
          w_next = IDLE;
          if (w_accept) begin
            w_next    = LAT0 ? RESP : WAIT;
            w_cnt_nxt = LAT_M1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the request on accept; capture the response at the access, clear it on handshake.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= s_bus.req_we;
        r_addr  <= s_bus.req_addr;
        r_wdata <= s_bus.req_wdata;
        r_be    <= s_bus.req_be;
      end
      if (w_access) begin
        r_rdata <= (w_acc_err || w_acc_we) ? 32'd0 : r_mem[w_acc_idx];
        r_err   <= w_acc_err;
      end else if (w_rsp_done) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // Array write: only enabled byte lanes of an in-range aligned store; contents never reset.
  always_ff @(posedge i_clk) begin
    if (w_access && w_acc_we && !w_acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
      end
    end
  end

  assign s_bus.req_ready = w_req_ready;
  assign s_bus.rsp_valid = (r_state == RESP);
  assign s_bus.rsp_rdata = r_rdata;
  assign s_bus.rsp_err   = r_err;

endmodule
